// File: rtl/shift_seq_ctrl.sv
// Step-timed sequencer for an external 6-bit rotate register, with debounced mode/pause buttons.
// Define SHIFT_SEQ_CTRL_BOUNCE_EN to build the BOUNCE (ping-pong) mode; default build cycles LEFT/RIGHT only.
module shift_seq_ctrl #(
  parameter int F_CLK_HZ    = 25_000_000,
  parameter int STEP_MS     = 500,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_pause,
  input  logic [5:0] q_in,
  output logic       shift_en,
  output logic       dir_left,
  output logic       load,
  output logic [5:0] load_val,
  output logic [2:0] state_o,
  output logic       led
);

  localparam int TICKS_PER_MS = F_CLK_HZ / 1000;
  localparam int STEP_TKS     = TICKS_PER_MS * STEP_MS;
  localparam int DB_TKS       = TICKS_PER_MS * DEBOUNCE_MS;
  localparam int STEP_W       = (STEP_TKS > 2) ? $clog2(STEP_TKS) : 1;
  localparam int DB_W         = (DB_TKS > 2) ? $clog2(DB_TKS) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = (STEP_TKS > 1) ? STEP_W'(STEP_TKS - 1) : '0;
  localparam logic [DB_W-1:0]   DB_LAST   = (DB_TKS > 1) ? DB_W'(DB_TKS - 1) : '0;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    LEFT   = 3'd1,
    RIGHT  = 3'd2,
    BOUNCE = 3'd3,
    PAUSE  = 3'd4
  } state_t;

  logic [STEP_W-1:0] step_cnt;
  logic              tick;
  logic [1:0]        btn_raw, sync1, sync2, db, db_d, press;
  logic [DB_W-1:0]   db_cnt [2];
  logic              mode_press, pause_press, mode_ev;
  state_t            state, next_state, saved, next_saved;
  logic              run, do_shift, do_load, shift_dir;
`ifdef SHIFT_SEQ_CTRL_BOUNCE_EN
  logic              bounce_dir, next_bounce_dir;
`endif

  assign tick = (step_cnt == STEP_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  step_cnt <= '0;
    else if (tick) step_cnt <= '0;
    else           step_cnt <= step_cnt + 1'b1;
  end

  // Bit 0 is the mode button, bit 1 the pause button.
  assign btn_raw = {btn_pause, btn_mode};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_d  <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      db_d  <= db;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press       = db & ~db_d;
  assign mode_press  = press[0];
  assign pause_press = press[1];
  // Pause wins a simultaneous press, so the mode event is dropped.
  assign mode_ev     = mode_press & ~pause_press;

  always_comb begin
    next_state = state;
    next_saved = saved;
    do_shift   = 1'b0;
    do_load    = 1'b0;
    shift_dir  = 1'b0;
`ifdef SHIFT_SEQ_CTRL_BOUNCE_EN
    next_bounce_dir = bounce_dir;
`endif
    run = (state == LEFT) || (state == RIGHT) || (state == BOUNCE);

    case (state)
      INIT: begin
        do_load    = 1'b1;
        next_state = LEFT;
      end
      LEFT: begin
        shift_dir = 1'b1;
        if (mode_ev) next_state = RIGHT;
      end
      RIGHT: begin
        shift_dir = 1'b0;
        if (mode_ev) begin
`ifdef SHIFT_SEQ_CTRL_BOUNCE_EN
          next_state      = BOUNCE;
          next_bounce_dir = 1'b1;
`else
          next_state      = LEFT;
`endif
        end
      end
`ifdef SHIFT_SEQ_CTRL_BOUNCE_EN
      BOUNCE: begin
        shift_dir = bounce_dir ? ~q_in[5] : q_in[0];
        if (mode_ev) next_state = LEFT;
      end
`endif
      PAUSE: begin
        if (pause_press) next_state = saved;
      end
      default: next_state = INIT;
    endcase

    if (run && pause_press) begin
      next_state = PAUSE;
      next_saved = state;
    end

    // A tick acts on the pre-transition state; an empty register is reloaded instead of shifted.
    if (run && tick) begin
      if (q_in != '0) do_shift = 1'b1;
      else            do_load  = 1'b1;
    end

`ifdef SHIFT_SEQ_CTRL_BOUNCE_EN
    if ((state == BOUNCE) && do_shift) next_bounce_dir = shift_dir;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= INIT;
      saved    <= LEFT;
      shift_en <= 1'b0;
      dir_left <= 1'b0;
      load     <= 1'b0;
      led      <= 1'b0;
`ifdef SHIFT_SEQ_CTRL_BOUNCE_EN
      bounce_dir <= 1'b1;
`endif
    end else begin
      state    <= next_state;
      saved    <= next_saved;
      shift_en <= do_shift;
      load     <= do_load;
      if (do_shift) dir_left <= shift_dir;
      if ((next_state == PAUSE) || (next_state == INIT)) led <= 1'b0;
      else if (do_shift)                                 led <= ~led;
`ifdef SHIFT_SEQ_CTRL_BOUNCE_EN
      bounce_dir <= next_bounce_dir;
`endif
    end
  end

  assign state_o  = state;
  assign load_val = 6'b000001;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl at F_CLK_HZ=1000, STEP_MS=4, DEBOUNCE_MS=2 (tick every 4 cycles).
// Compile with SHIFT_SEQ_CTRL_BOUNCE_EN defined to also cover BOUNCE mode.
`timescale 1ns/1ps
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_mode;
  logic       btn_pause;
  logic [5:0] q_in;
  logic       shift_en;
  logic       dir_left;
  logic       load;
  logic [5:0] load_val;
  logic [2:0] state_o;
  logic       led;

  logic [5:0] q_reg;
  logic       force_zero;
  logic       saw_three = 1'b0;
  int         tests_run = 0;
  int         tests_failed = 0;

  shift_seq_ctrl #(
    .F_CLK_HZ   (1000),
    .STEP_MS    (4),
    .DEBOUNCE_MS(2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn_mode (btn_mode),
    .btn_pause(btn_pause),
    .q_in     (q_in),
    .shift_en (shift_en),
    .dir_left (dir_left),
    .load     (load),
    .load_val (load_val),
    .state_o  (state_o),
    .led      (led)
  );

  always #5 clk = ~clk;

  // Stand-in for the controlled 6-bit rotate register.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)      q_reg <= 6'd0;
    else if (load)     q_reg <= load_val;
    else if (shift_en) q_reg <= dir_left ? {q_reg[4:0], q_reg[5]} : {q_reg[0], q_reg[5:1]};
  end

  assign q_in = force_zero ? 6'd0 : q_reg;

  always @(negedge clk) if (state_o == 3'd3) saw_three <= 1'b1;

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_until(input logic m, input logic p, input logic [2:0] target,
                             input int budget, output int lat);
    btn_mode  = m;
    btn_pause = p;
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (state_o == target) begin
        lat = k;
        break;
      end
    end
    btn_mode  = 1'b0;
    btn_pause = 1'b0;
  endtask

  task automatic wait_shift(input int budget, output int waited);
    waited = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (shift_en) begin
        waited = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    btn_mode   = 1'b0;
    btn_pause  = 1'b0;
    force_zero = 1'b0;
    settle(3);
    tests_run++;
    if ({shift_en, dir_left, load, led, state_o} !== 7'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %b expected 0000000", {shift_en, dir_left, load, led, state_o});
    end
    tests_run++;
    if (load_val !== 6'b000001) begin
      tests_failed++;
      $display("[TB] FAIL load_val: got %b expected 000001", load_val);
    end
  endtask

  task automatic test_reset_release();
    int loads = 0, shifts = 0, bad_shift = 0;
    logic [2:0] st1 = 3'd7;
    logic ld1 = 1'b0, led4 = 1'b0, led8 = 1'b1;
    reset_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (load) loads++;
      if (k == 1) begin
        st1 = state_o;
        ld1 = load;
      end
      if (shift_en) begin
        shifts++;
        if ((k % 4) != 0 || dir_left !== 1'b1) bad_shift++;
      end
      if (k == 4) led4 = led;
      if (k == 8) led8 = led;
    end
    tests_run++;
    if (ld1 !== 1'b1) begin tests_failed++; $display("[TB] FAIL init_load_first_edge: got %b expected 1", ld1); end
    tests_run++;
    if (loads !== 1) begin tests_failed++; $display("[TB] FAIL init_load_count: got %0d expected 1", loads); end
    tests_run++;
    if (st1 !== 3'd1) begin tests_failed++; $display("[TB] FAIL init_to_left: got %0d expected 1", st1); end
    tests_run++;
    if (shifts !== 4) begin tests_failed++; $display("[TB] FAIL left_shift_count: got %0d expected 4", shifts); end
    tests_run++;
    if (bad_shift !== 0) begin tests_failed++; $display("[TB] FAIL left_shift_phase_dir: got %0d bad expected 0", bad_shift); end
    tests_run++;
    if ({led4, led8} !== 2'b10) begin tests_failed++; $display("[TB] FAIL led_toggle: got %b expected 10", {led4, led8}); end
  endtask

  task automatic test_glitch();
    btn_mode = 1'b1;
    @(negedge clk);
    btn_mode = 1'b0;
    settle(10);
    tests_run++;
    if (state_o !== 3'd1) begin tests_failed++; $display("[TB] FAIL glitch_ignored: got %0d expected 1", state_o); end
  endtask

  task automatic test_mode();
    int lat, w;
    press_until(1'b1, 1'b0, 3'd2, 10, lat);
    tests_run++;
    if (lat !== 5) begin tests_failed++; $display("[TB] FAIL mode_left_to_right: got latency %0d expected 5", lat); end
    wait_shift(8, w);
    tests_run++;
    if (w < 0 || dir_left !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL right_dir: got wait %0d dir %b expected shift with dir 0", w, dir_left);
    end
    settle(8);
  endtask

`ifdef SHIFT_SEQ_CTRL_BOUNCE_EN
  task automatic test_bounce();
    int lat, w, got = -1, bad = 0;
    logic [10:0] exp_dirs;
    logic [5:0]  q_exp;
    exp_dirs = 11'b100_0001_1111;
    force_zero = 1'b1;
    press_until(1'b1, 1'b0, 3'd3, 10, lat);
    tests_run++;
    if (lat !== 5) begin tests_failed++; $display("[TB] FAIL mode_right_to_bounce: got latency %0d expected 5", lat); end
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (shift_en) bad++;
      if (load) begin
        got = i;
        break;
      end
    end
    force_zero = 1'b0;
    tests_run++;
    if (got < 0 || bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL bounce_reload: got wait %0d shifts %0d expected load with 0 shifts", got, bad);
    end
    q_exp = 6'b000001;
    for (int n = 0; n < 11; n++) begin
      wait_shift(8, w);
      tests_run++;
      if (w < 0 || {q_in, dir_left} !== {q_exp, exp_dirs[n]}) begin
        tests_failed++;
        $display("[TB] FAIL bounce_step%0d: got q %b dir %b expected q %b dir %b", n, q_in, dir_left, q_exp, exp_dirs[n]);
      end
      q_exp = exp_dirs[n] ? {q_exp[4:0], q_exp[5]} : {q_exp[0], q_exp[5:1]};
    end
    settle(2);
  endtask
`endif

  task automatic test_mode_cycle();
    int lat;
`ifdef SHIFT_SEQ_CTRL_BOUNCE_EN
    press_until(1'b1, 1'b0, 3'd1, 10, lat);
    tests_run++;
    if (lat !== 5) begin tests_failed++; $display("[TB] FAIL mode_bounce_to_left: got latency %0d expected 5", lat); end
`else
    press_until(1'b1, 1'b0, 3'd1, 10, lat);
    tests_run++;
    if (lat !== 5) begin tests_failed++; $display("[TB] FAIL mode_right_to_left: got latency %0d expected 5", lat); end
`endif
    settle(8);
    press_until(1'b1, 1'b0, 3'd2, 10, lat);
    tests_run++;
    if (lat !== 5) begin tests_failed++; $display("[TB] FAIL mode_left_to_right_again: got latency %0d expected 5", lat); end
    settle(8);
  endtask

  task automatic test_pause();
    int lat, w, shifts = 0, led_on = 0;
    logic l1;
    press_until(1'b0, 1'b1, 3'd4, 10, lat);
    tests_run++;
    if (lat !== 5) begin tests_failed++; $display("[TB] FAIL pause_enter: got latency %0d expected 5", lat); end
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (shift_en) shifts++;
      if (led) led_on++;
    end
    tests_run++;
    if (shifts !== 0) begin tests_failed++; $display("[TB] FAIL pause_no_shift: got %0d shifts expected 0", shifts); end
    tests_run++;
    if (led_on !== 0) begin tests_failed++; $display("[TB] FAIL pause_led_low: got %0d cycles high expected 0", led_on); end
    btn_mode = 1'b1;
    settle(5);
    btn_mode = 1'b0;
    settle(8);
    tests_run++;
    if (state_o !== 3'd4) begin tests_failed++; $display("[TB] FAIL pause_mode_discard: got %0d expected 4", state_o); end
    press_until(1'b0, 1'b1, 3'd2, 10, lat);
    tests_run++;
    if (lat !== 5) begin tests_failed++; $display("[TB] FAIL pause_resume_right: got latency %0d expected 5", lat); end
    wait_shift(8, w);
    l1 = led;
    tests_run++;
    if (w < 0 || dir_left !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL resume_shift: got wait %0d dir %b expected shift with dir 0", w, dir_left);
    end
    wait_shift(8, w);
    tests_run++;
    if (w < 0 || led === l1) begin
      tests_failed++;
      $display("[TB] FAIL resume_led_toggle: got wait %0d led %b expected %b", w, led, ~l1);
    end
    settle(6);
  endtask

  task automatic test_simultaneous();
    int lat;
`ifdef SHIFT_SEQ_CTRL_BOUNCE_EN
    press_until(1'b1, 1'b0, 3'd3, 10, lat);
    settle(8);
`endif
    press_until(1'b1, 1'b0, 3'd1, 10, lat);
    settle(8);
    tests_run++;
    if (state_o !== 3'd1) begin tests_failed++; $display("[TB] FAIL simul_setup_left: got %0d expected 1", state_o); end
    press_until(1'b1, 1'b1, 3'd4, 10, lat);
    tests_run++;
    if (lat !== 5) begin tests_failed++; $display("[TB] FAIL simul_pause_wins: got latency %0d expected 5", lat); end
    settle(8);
    press_until(1'b0, 1'b1, 3'd1, 10, lat);
    settle(8);
    tests_run++;
    if (lat !== 5 || state_o !== 3'd1) begin
      tests_failed++;
      $display("[TB] FAIL simul_resume_left: got latency %0d state %0d expected 5 and 1", lat, state_o);
    end
  endtask

  task automatic test_recovery();
    int got = -1, bad = 0, w;
    force_zero = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (shift_en) bad++;
      if (load) begin
        got = i;
        break;
      end
    end
    force_zero = 1'b0;
    tests_run++;
    if (got < 0) begin tests_failed++; $display("[TB] FAIL recovery_load: got no load expected load within 8 cycles"); end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("[TB] FAIL recovery_no_shift: got %0d shifts expected 0", bad); end
    wait_shift(8, w);
    tests_run++;
    if (w < 0 || {q_in, dir_left} !== 7'b0000011) begin
      tests_failed++;
      $display("[TB] FAIL recovery_resume: got wait %0d q %b dir %b expected q 000001 dir 1", w, q_in, dir_left);
    end
  endtask

  task automatic test_reset_mid();
    int lat, loads = 0;
    logic [2:0] st1 = 3'd7;
    press_until(1'b0, 1'b1, 3'd4, 10, lat);
    tests_run++;
    if (lat !== 5) begin tests_failed++; $display("[TB] FAIL mid_pause_enter: got latency %0d expected 5", lat); end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({shift_en, load, led, state_o} !== 6'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got %b expected 000000", {shift_en, load, led, state_o});
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (load) loads++;
      if (k == 1) st1 = state_o;
    end
    tests_run++;
    if (loads !== 1 || st1 !== 3'd1) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_restart: got loads %0d state %0d expected 1 and 1", loads, st1);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_reset_release();
    test_glitch();
    test_mode();
`ifdef SHIFT_SEQ_CTRL_BOUNCE_EN
    test_bounce();
`endif
    test_mode_cycle();
    test_pause();
    test_simultaneous();
    test_recovery();
    test_reset_mid();
`ifndef SHIFT_SEQ_CTRL_BOUNCE_EN
    tests_run++;
    if (saw_three !== 1'b0) begin tests_failed++; $display("[TB] FAIL no_bounce_code: got code 3 seen expected never"); end
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 The block SHALL have parameter F_CLK_HZ, default 25_000_000, clock frequency in Hz.
REQ-002 The block SHALL have parameter STEP_MS, default 500, interval between shift steps in ms.
REQ-003 The block SHALL have parameter DEBOUNCE_MS, default 20, button stability window in ms.
REQ-004 clk  input  1  single system clock, rising edge.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 btn_mode  input  1  mode button, active-high, asynchronous to clk.
REQ-007 btn_pause  input  1  pause button, active-high, asynchronous to clk.
REQ-008 q_in  input  6  parallel feedback from the controlled 6-bit rotate register.
REQ-009 shift_en  output  1  one-cycle strobe; register shifts when high.
REQ-010 dir_left  output  1  1 = rotate left (LSB→MSB), 0 = rotate right; valid while shift_en=1.
REQ-011 load  output  1  one-cycle strobe; register loads load_val.
REQ-012 load_val  output  6  value to load; constant 6'b000001.
REQ-013 state_o  output  3  current FSM state code.
REQ-014 led  output  1  activity indicator.

Function
REQ-015 Derived: TICKS_PER_MS = F_CLK_HZ/1000; STEP_TKS = TICKS_PER_MS*STEP_MS; DB_TKS = TICKS_PER_MS*DEBOUNCE_MS.
REQ-016 Step counter free-runs 0..STEP_TKS-1 and wraps; tick = 1 for exactly the cycle when the count equals STEP_TKS-1; if STEP_TKS ≤ 1, tick = 1 every cycle.
REQ-017 Each button passes through a 2-FF synchronizer, then a debouncer: debounced level changes only after the synchronized level differs from it for DB_TKS consecutive cycles (DB_TKS ≤ 1: 1 cycle).
REQ-018 A press event is a one-cycle pulse on the debounced 0→1 edge; release produces no event.
REQ-019 FSM states and codes: INIT=0, LEFT=1, RIGHT=2, BOUNCE=3, PAUSE=4.
REQ-020 INIT: load=1 for one cycle, then LEFT unconditionally on the next cycle.
REQ-021 Mode press in LEFT→RIGHT, RIGHT→BOUNCE, BOUNCE→LEFT; transition takes effect on the next cycle.
REQ-022 Pause press in LEFT/RIGHT/BOUNCE → PAUSE, saving the run state; pause press in PAUSE → saved state; mode press in PAUSE is discarded.
REQ-023 Pause and mode press in the same cycle: pause is processed, mode is discarded.
REQ-024 shift_en = tick AND state ∈ {LEFT, RIGHT, BOUNCE} AND q_in ≠ 0; no shift in INIT or PAUSE.
REQ-025 If tick occurs in a run state with q_in = 0, load=1 for that cycle instead of shift_en (recovery).
REQ-026 dir_left: LEFT=1; RIGHT=0; BOUNCE: if bounce_dir=1 then !q_in[5], else q_in[0].
REQ-027 bounce_dir is set to 1 on every entry into BOUNCE from RIGHT, retained across PAUSE, and updated to dir_left on every BOUNCE shift.
REQ-028 led toggles on every shift_en; held at 0 in PAUSE and INIT.
REQ-029 A step tick and a press event in the same cycle: the shift uses the current (pre-transition) state.

Reset
REQ-030 On reset_n=0, all outputs are asynchronously forced: shift_en=0, dir_left=0, load=0, state_o=INIT, led=0; step and debounce counters=0; synchronizers and debounced levels=0; bounce_dir=1; saved state=LEFT.
REQ-031 After reset_n deasserts, INIT executes on the first clk edge, producing exactly one load pulse.
REQ-032 Reset mid-operation (any state, including PAUSE) discards the saved state and restarts from INIT.

Configuration
REQ-033 Macro SHIFT_SEQ_CTRL_BOUNCE_EN: when defined, BOUNCE exists as specified.
REQ-034 Without SHIFT_SEQ_CTRL_BOUNCE_EN: a mode press cycles LEFT↔RIGHT only; code 3 is never produced; bounce_dir logic is absent.

Verification (F_CLK_HZ=1000, STEP_MS=4, DEBOUNCE_MS=2 → tick every 4 cycles, DB 2 cycles)
REQ-035 Reset release → exactly one load pulse with load_val=000001, state_o 0→1, shift_en every 4th cycle with dir_left=1.
REQ-036 Mode press held 5 cycles in LEFT → state_o=2, dir_left=0 on subsequent ticks; a 1-cycle glitch on btn_mode produces no transition.
REQ-037 BOUNCE with q_in sequence 000001..100000 fed back → dir_left=1 for five shifts, 0 when q_in=100000, 1 again when q_in=000001.
REQ-038 Pause press in RIGHT → state_o=4, no shift_en or led toggle for 20 cycles; second pause press → state_o=2, shifts resume.
REQ-039 Pause and mode pressed simultaneously in LEFT → state_o=4; after un-pause → state_o=1.
REQ-040 q_in forced to 000000 in LEFT → load=1 at the next tick, shift_en=0 on that tick.
